// File: rtl/arith_pkg.sv
// Shared definitions for the shift-add arithmetic blocks: FSM state
// encodings and the default operand width.
package arith_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SQUARE = 2'd1,
    S_CUBE   = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_step.sv
// One shift-add multiplication step: adds (mcand << shamt) to the
// accumulator when the current multiplier bit is set.
module shift_add_step #(
  parameter int unsigned AW = 24,
  parameter int unsigned SW = 4
) (
  input  logic [AW-1:0] acc_i,
  input  logic [AW-1:0] mcand_i,
  input  logic          bit_i,
  input  logic [SW-1:0] shamt_i,
  output logic [AW-1:0] acc_o
);

  // Conditional add of the shifted multiplicand
  always_comb begin
    acc_o = acc_i;
    if (bit_i) begin
      acc_o = acc_i + (mcand_i << shamt_i);
    end else begin
      acc_o = acc_i;
    end
  end

endmodule

// File: rtl/cube_calc.sv
// Sequential x^3 unit: squares x, then multiplies the square by x, each phase
// a W-cycle LSB-first shift-add through a single shared step unit.
module cube_calc
  import arith_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [W-1:0]     x_bi,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3*W-1:0]   y_bo
);

  localparam int unsigned AW = 3 * W;
  localparam int unsigned IW = $clog2(W);
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [2*W-1:0]  sq_q, sq_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   y_q, y_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [AW-1:0]   mcand_s;
  logic            step_bit_s;
  logic [AW-1:0]   step_acc_s;

  // SQUARE multiplies x by x, CUBE multiplies the square by x
  always_comb begin
    mcand_s = AW'(x_q);
    if (state_q == S_CUBE) begin
      mcand_s = AW'(sq_q);
    end else begin
      mcand_s = AW'(x_q);
    end
    step_bit_s = x_q[cnt_q[IW-1:0]];
  end

  shift_add_step #(
    .AW (AW),
    .SW (CW)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_s),
    .bit_i   (step_bit_s),
    .shamt_i (cnt_q),
    .acc_o   (step_acc_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_bi;
          y_d     = '0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SQUARE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SQUARE: begin
        if (cnt_q == LAST) begin
          sq_d    = step_acc_s[2*W-1:0];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CUBE;
        end else begin
          acc_d = step_acc_s;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CUBE: begin
        if (cnt_q == LAST) begin
          y_d     = step_acc_s;
          done_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc_s;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      sq_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_cube_calc.sv
// Directed self-checking bench for cube_calc (W=8).
module tb_cube_calc;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  x_bi;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic [23:0] y_bo;

  int n_vec;
  int n_err;

  cube_calc #(.W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .x_bi    (x_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .y_bo    (y_bo)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One start pulse with operand x; optionally scramble x_bi while busy.
  task automatic run(input logic [7:0] x, input logic [31:0] exp, input bit scramble);
    @(negedge clk_i);
    x_bi    = x;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check("accept_busy", {31'd0, busy_o}, 32'd1);
    check("accept_y_clear", {8'd0, y_bo}, 32'd0);
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk_i);
      #1;
      if (scramble) x_bi = 8'($urandom_range(0, 255));
      if (c == 15) begin
        check("busy_c15", {31'd0, busy_o}, 32'd1);
        check("done_c15", {31'd0, done_o}, 32'd0);
      end
      if (c == 16) begin
        check("busy_c16", {31'd0, busy_o}, 32'd0);
        check("done_c16", {31'd0, done_o}, 32'd1);
        check("y_c16", {8'd0, y_bo}, exp);
      end
      if (c == 17) begin
        check("done_c17", {31'd0, done_o}, 32'd0);
        check("y_hold", {8'd0, y_bo}, exp);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_i   = 1'b0;
    start_i = 1'b0;
    x_bi    = 8'd0;
    #12;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_y", {8'd0, y_bo}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    run(8'd0, 32'd0, 1'b0);
    run(8'd3, 32'd27, 1'b0);
    run(8'd6, 32'd216, 1'b0);
    run(8'd255, 32'd16581375, 1'b0);

    // start held high: re-acceptance one edge after each return to idle
    @(negedge clk_i);
    x_bi    = 8'd5;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int c = 1; c <= 51; c++) begin
      @(posedge clk_i);
      #1;
      check("held_busy", {31'd0, busy_o},
            (c == 16 || c == 33 || c >= 50) ? 32'd0 : 32'd1);
      check("held_done", {31'd0, done_o},
            (c == 16 || c == 33 || c == 50) ? 32'd1 : 32'd0);
      if (c == 16 || c == 33 || c == 50) check("held_y", {8'd0, y_bo}, 32'd125);
      if (c == 39) start_i = 1'b0;
    end

    // reset in the middle of a computation
    @(negedge clk_i);
    x_bi    = 8'd200;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk_i);
    end
    #1;
    check("mid_busy_pre", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_done", {31'd0, done_o}, 32'd0);
    check("mid_rst_y", {8'd0, y_bo}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    run(8'd2, 32'd8, 1'b0);

    run(8'd10, 32'd1000, 1'b1);

    for (int x = 0; x < 256; x++) begin
      run(8'(x), 32'(x * x * x), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
